inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction fetch front end: owns the program counter, drives the synchronous instruction ROM's address port, absorbs the ROM's one-cycle read latency, and presents instructions with their PC to decode over a valid/ready handshake. It sits between `fetch_instruction_ROM`, which is read by this block, and the decode stage. It supports decode back-pressure and branch redirects without dropping or duplicating instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `ROM_AW`, 6: ROM word-address width. `rom_addr = pc[ROM_AW+1:2]`.

Ports:
- `clk` in 1: single clock; ROM shares it.
- `rst` in 1: synchronous, active-high reset.
- `rom_addr` out `ROM_AW`: ROM read address, combinational, sampled by the ROM on `clk` rising edge.
- `rom_data` in 32: ROM read data; valid in the cycle after its address was issued.
- `redirect_valid` in 1: branch or exception redirect request; single-cycle pulse.
- `redirect_pc` in 32: redirect target byte address; bits [1:0] are ignored.
- `inst_valid` out 1: the output buffer head is valid.
- `inst` out 32: instruction word at the head.
- `inst_pc` out 32: byte address of `inst`, with bits [1:0] = 0.
- `inst_ready` in 1: decode accepts the head. Pop occurs when `inst_valid && inst_ready`.
- `halted` out 1: fetch stopped. Exists only with `FETCH_ZERO_HALT_EN`.

## Operation
- **State:**
  - `pc`: next fetch address.
  - `inflight` bit plus `inflight_pc`: the read issued last cycle.
  - 2-entry output FIFO holding {inst, pc}.
- **Issue condition:** `occ + inflight - pop < 2`, where `pop = inst_valid && inst_ready`. Not halted. Reset not active.
- **On issue:**
  - `rom_addr` is taken from `pc`.
  - `inflight_pc <= pc`, `pc <= pc + 4`.
  - `inflight <= 1`.
- **When not issuing:** `inflight <= 0`. `rom_addr` still shows `pc` and is don't-care for the ROM.
- **Data return:** if `inflight` is set and there is no redirect this cycle, write {`rom_data`, `inflight_pc`} into the FIFO.
- **Credit rule:** the FIFO never overflows by construction. An assertion checks write-when-full.
- **Redirect (cycle with `redirect_valid = 1`):**
  - `rom_addr = redirect_pc[ROM_AW+1:2]`; this issue is unconditional.
  - `inflight_pc <= {redirect_pc[31:2], 2'b00}`.
  - `pc <= {redirect_pc[31:2], 2'b00} + 4`.
  - `inflight <= 1`.
  - The FIFO is flushed to empty.
  - Returning `rom_data` from the previous issue is discarded.
  - A concurrent pop still counts as delivered to decode.
  - Redirect also clears `halted`.
- **Redirect overrides:** back-to-back redirects each win; only the last target's stream survives.
- **PC wrap:** `pc` is 32-bit and wraps 32'hFFFF_FFFC → 0. `rom_addr` aliases modulo 2^`ROM_AW` words. ROM zero-fill beyond programme end is delivered as data.
- **Back-pressure:** while `inst_valid && !inst_ready`, outputs `inst`/`inst_pc` hold stable.

## Timing
- **Reset values:**
  - `inst_valid = 0`, `inst = 0`, `inst_pc = 0`.
  - `pc = RESET_PC`, `inflight = 0`, FIFO empty.
  - `halted = 0`.
  - `rom_addr = RESET_PC[ROM_AW+1:2]`.
- **Reset mid-operation:** all in-flight and buffered instructions are dropped. The first post-reset issue occurs in the first cycle with `rst = 0`.
- **Latency:**
  - Issue in cycle t → ROM data in t+1 → `inst_valid` in t+2.
  - The same applies after a redirect: the target appears 2 cycles after `redirect_valid`.
- **Throughput:** 1 instruction/cycle sustained with `inst_ready` held high.
- **Stall recovery:** after any stall, the buffer holds ≤2 entries. Release of `inst_ready` gives back-to-back delivery without bubbles.

## Configuration
- **`FETCH_ZERO_HALT_EN` defined:**
  - A returning word equal to 32'h0000_0000 is not written to the FIFO.
  - `halted` is set, issue stops, and `inflight` clears.
  - Instructions already buffered still drain.
  - Exit is by reset or redirect only.
- **Undefined:** the `halted` port is absent and zero words are delivered as ordinary instructions.

## Structure
- **Shared package `cpu_pkg`:**
  - `INST_W = 32`.
  - `inst_t`, `pc_t` typedefs.
  - `FETCH_RESET_PC` constant.
  - `ZERO_INST = 32'h0`.
- **Sub-module `fetch_skid_fifo`:**
  - 2-entry, {inst, pc} payload.
  - Ports: push, pop, flush, `occ`, head outputs.
- **Top:** PC/credit/redirect control.

## Test plan
- **Reset, ROM loaded with programme words 0x13a0000c, 0xe3a01004, 0x33a05000…, `inst_ready = 1`:**
  - `inst_valid` rises 2 cycles after reset release, with `inst = 0x13a0000c`, `inst_pc = 0`.
  - Next cycles give 0xe3a01004/4, then 0x33a05000/8, with no bubbles.
- **Back-pressure:** hold `inst_ready = 0` for 5 cycles after the first valid.
  - The head stays 0x13a0000c/0 and `rom_addr` stops advancing.
  - On release, deliver pc 4, 8, 12 on consecutive cycles with no loss or duplicate.
- **Redirect to 0x1E, with a pop in the same cycle:**
  - The popped instruction counts.
  - The next delivered instruction is pc 0x1C (0xe5803004) 2 cycles later; no stale instruction appears.
- **Run past word 11:**
  - Without the macro, pc 0x30 delivers 0x00000000.
  - With `FETCH_ZERO_HALT_EN`, `halted` rises, the FIFO drains to pc 0x2C (0xe1016090), and nothing further is delivered.
- **Halted, then redirect to 0:** `halted` clears and 0x13a0000c/0 is delivered 2 cycles later.
- **Assert `rst` while the FIFO is full:** `inst_valid = 0` the next cycle and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction/PC words, the fetch buffer
// entry bundle, reset PC and word-alignment helper.
package cpu_pkg;

    localparam int INST_W = 32;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [31:0]       pc_t;

    localparam pc_t   FETCH_RESET_PC = 32'h0000_0000;
    localparam inst_t ZERO_INST      = 32'h0000_0000;

    // One buffered instruction with the byte address it was fetched from.
    typedef struct packed {
        inst_t inst;
        pc_t   pc;
    } fetch_entry_t;

    // Clear the byte-offset bits of an address.
    function automatic pc_t word_align(input pc_t a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer between fetch and decode; entry 0 is always the
// head, so the head holds stable while no pop occurs.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   push/push_entry - write one {inst, pc} entry
//   pop             - remove the head (ignored when empty)
//   flush           - drop all entries (wins over push/pop)
//   occ             - number of valid entries (0..2)
//   head_valid/head - head entry and its valid flag
module fetch_skid_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   occ,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t entry0_q, entry0_d;
    fetch_entry_t entry1_q, entry1_d;
    logic [1:0]   occ_q, occ_d;
    logic         pop_i;

    assign pop_i = pop && (occ_q != 2'd0);

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        occ_d    = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            unique case ({push, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) entry0_d = push_entry;
                    else               entry1_d = push_entry;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    occ_d    = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        entry0_d = push_entry;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            occ_q    <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            occ_q    <= occ_d;
        end
    end

    // Fetch credit accounting must never push into a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop_i && !flush && occ_q == 2'd2));

    assign occ        = occ_q;
    assign head_valid = (occ_q != 2'd0);
    assign head       = entry0_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, ROM address issue, one-cycle ROM
// latency tracking, credit-based issue into a 2-entry output buffer and
// branch redirects. Optional macro FETCH_ZERO_HALT_EN stops fetch on a
// returned all-zero word and adds the halted output.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   rom_addr / rom_data        - synchronous ROM read port
//   redirect_valid/redirect_pc - one-cycle redirect to a new target
//   inst_valid/inst/inst_pc    - head of buffer to decode
//   inst_ready                 - decode accepts the head
//   halted                     - fetch stopped (FETCH_ZERO_HALT_EN only)
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter pc_t RESET_PC = FETCH_RESET_PC,
    parameter int  ROM_AW   = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready
`ifdef FETCH_ZERO_HALT_EN
    ,
    output logic              halted
`endif
);

    pc_t  pc_q, pc_d;
    pc_t  inflight_pc_q, inflight_pc_d;
    logic inflight_q, inflight_d;

    pc_t          fetch_pc;
    logic         pop;
    logic         ret_valid;
    logic         push;
    logic         issue;
    logic         credit_ok;
    logic         halt_blk;
    logic [1:0]   occ;
    fetch_entry_t push_entry;
    fetch_entry_t head;

`ifdef FETCH_ZERO_HALT_EN
    logic halted_q, halted_d;
    logic halt_now;
`endif

    always_comb begin
        pop       = inst_valid && inst_ready;
        fetch_pc  = redirect_valid ? word_align(redirect_pc) : pc_q;
        rom_addr  = ROM_AW'(fetch_pc >> 2);
        // Data for a read issued before a redirect is stale.
        ret_valid = inflight_q && !redirect_valid;
`ifdef FETCH_ZERO_HALT_EN
        halt_now  = ret_valid && (rom_data == ZERO_INST);
        halt_blk  = halted_q || halt_now;
        push      = ret_valid && !halt_now;
        halted_d  = halted_q;
        if (redirect_valid) halted_d = 1'b0;
        else if (halt_now)  halted_d = 1'b1;
`else
        halt_blk  = 1'b0;
        push      = ret_valid;
`endif
        // Buffered + in flight - leaving must leave room for one more.
        credit_ok = ({1'b0, occ} + {2'b00, inflight_q})
                    < (3'd2 + {2'b00, pop});
        issue     = redirect_valid || (credit_ok && !halt_blk);

        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (issue) begin
            inflight_pc_d = fetch_pc;
            pc_d          = fetch_pc + 32'd4;
        end

        push_entry.inst = rom_data;
        push_entry.pc   = inflight_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

`ifdef FETCH_ZERO_HALT_EN
    always_ff @(posedge clk) begin
        if (rst) halted_q <= 1'b0;
        else     halted_q <= halted_d;
    end

    assign halted = halted_q;
`endif

    fetch_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .occ        (occ),
        .head_valid (inst_valid),
        .head       (head)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

endmodule
